// File: rtl/serial_frame_pkg.sv
// Shared types and helpers for the serial frame scheduler: FSM state encoding,
// field widths and the active-low seven-segment decode.
package serial_frame_pkg;

  localparam int ID_W  = 2;
  localparam int LEN_W = 4;
  localparam int PAY_W = 16;

  localparam logic [6:0] HEX_BLANK = 7'h7F;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_PORT  = 3'd2,
    ST_LEN   = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } state_t;

  // Segment order is {g,f,e,d,c,b,a}, a lit segment drives 0.
  function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = HEX_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first eligible requester at or after ptr,
// with the just-served port excluded through mask.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic [N-1:0]   mask,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid
);

  logic [N-1:0]   w_elig;
  logic [IDW-1:0] w_idx;

  assign w_elig = req & ~mask;

  // Rotating priority search starting at ptr.
  always_comb begin
    gnt       = '0;
    gnt_id    = '0;
    gnt_valid = 1'b0;
    w_idx     = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = IDW'((int'(ptr) + i) % N);
      if (!gnt_valid && w_elig[w_idx]) begin
        gnt_valid  = 1'b1;
        gnt_id     = w_idx;
        gnt[w_idx] = 1'b1;
      end else begin
        gnt_valid = gnt_valid;
      end
    end
  end

endmodule

// File: rtl/serial_frame_scheduler.sv
// Shares one strobe-paced serial line between N requesters, sending each grant
// as a frame of start, port ID, length, LSB-first payload and stop symbols.
module serial_frame_scheduler
  import serial_frame_pkg::*;
#(
  parameter int N  = 1 << ID_W,
  parameter int LW = LEN_W,
  parameter int DW = PAY_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [N-1:0]  req,
  input  logic [N*LW-1:0] len_bus,
  input  logic [N*DW-1:0] data_bus,
  output logic          serOut,
  output logic          serOutValid,
  output logic          busy,
  output logic [N-1:0]  ack,
  output logic [6:0]    hex_out
);

  localparam int IDW = $clog2(N);
  localparam int HW  = IDW + LW;

  state_t         r_state;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_id;
  logic [N-1:0]   r_gnt;
  logic [LW-1:0]  r_len;
  logic [LW-1:0]  r_cnt;
  logic [HW-1:0]  r_hdr;
  logic [DW-1:0]  r_pay;
  logic           r_ser;
  logic           r_valid;
  logic           r_busy;
  logic [N-1:0]   r_ack;
  logic [6:0]     r_hex;

  logic [IDW-1:0] w_ptr_next;
  logic [IDW-1:0] w_arb_ptr;
  logic [N-1:0]   w_mask;
  logic [N-1:0]   w_gnt;
  logic [IDW-1:0] w_gnt_id;
  logic           w_gnt_valid;
  logic [LW-1:0]  w_gnt_len;
  logic [DW-1:0]  w_gnt_data;
  logic           w_start;

  rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
    .req      (req),
    .ptr      (w_arb_ptr),
    .mask     (w_mask),
    .gnt      (w_gnt),
    .gnt_id   (w_gnt_id),
    .gnt_valid(w_gnt_valid)
  );

  // At STOP the arbiter already sees the advanced pointer so back-to-back grants need no idle cycle.
  always_comb begin
    w_ptr_next = r_id + IDW'(1);
    if (r_id == IDW'(N - 1)) begin
      w_ptr_next = '0;
    end else begin
      w_ptr_next = r_id + IDW'(1);
    end
    if (r_state == ST_STOP) begin
      w_arb_ptr = w_ptr_next;
      w_mask    = r_gnt;
    end else begin
      w_arb_ptr = r_ptr;
      w_mask    = '0;
    end
    if (w_gnt_valid && (r_state == ST_IDLE || r_state == ST_STOP)) begin
      w_start = 1'b1;
    end else begin
      w_start = 1'b0;
    end
    w_gnt_len  = len_bus[w_gnt_id*LW +: LW];
    w_gnt_data = data_bus[w_gnt_id*DW +: DW];
  end

  // Frame sequencer: each en step puts the next symbol on the registered line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_id    <= '0;
      r_gnt   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_hdr   <= '0;
      r_pay   <= '0;
      r_ser   <= 1'b1;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_ack   <= '0;
      r_hex   <= HEX_BLANK;
    end else begin
      r_ack <= '0;
      if (en) begin
        if (r_state == ST_STOP) begin
          r_ack <= r_gnt;
          r_ptr <= w_ptr_next;
        end
        if (w_start) begin
          r_state <= ST_START;
          r_ser   <= 1'b0;
          r_valid <= 1'b0;
          r_busy  <= 1'b1;
          r_id    <= w_gnt_id;
          r_gnt   <= w_gnt;
          r_len   <= w_gnt_len;
          r_hdr   <= {w_gnt_id, w_gnt_len};
          r_pay   <= w_gnt_data;
          r_hex   <= seg7_decode(4'(w_gnt_len));
        end else begin
          case (r_state)
            ST_IDLE: r_ser <= 1'b1;
            ST_START: begin
              r_ser   <= r_hdr[HW-1];
              r_hdr   <= r_hdr << 1;
              r_cnt   <= LW'(IDW - 1);
              r_state <= ST_PORT;
            end
            // ID and length are one contiguous MSB-first header; the counter only tracks the field boundary.
            ST_PORT: begin
              r_ser <= r_hdr[HW-1];
              r_hdr <= r_hdr << 1;
              if (r_cnt != '0) begin
                r_cnt <= r_cnt - LW'(1);
              end else begin
                r_cnt   <= LW'(LW - 1);
                r_state <= ST_LEN;
              end
            end
            ST_LEN: begin
              if (r_cnt != '0) begin
                r_ser <= r_hdr[HW-1];
                r_hdr <= r_hdr << 1;
                r_cnt <= r_cnt - LW'(1);
              end else if (r_len == '0) begin
                r_ser   <= 1'b1;
                r_state <= ST_STOP;
              end else begin
                r_ser   <= r_pay[0];
                r_pay   <= r_pay >> 1;
                r_valid <= 1'b1;
                r_cnt   <= r_len - LW'(1);
                r_state <= ST_DATA;
              end
            end
            ST_DATA: begin
              if (r_cnt != '0) begin
                r_ser <= r_pay[0];
                r_pay <= r_pay >> 1;
                r_cnt <= r_cnt - LW'(1);
              end else begin
                r_ser   <= 1'b1;
                r_valid <= 1'b0;
                r_state <= ST_STOP;
              end
            end
            ST_STOP: begin
              r_state <= ST_IDLE;
              r_ser   <= 1'b1;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_hex   <= HEX_BLANK;
            end
            default: begin
              r_state <= ST_IDLE;
              r_ser   <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign serOut      = r_ser;
  assign serOutValid = r_valid;
  assign busy        = r_busy;
  assign ack         = r_ack;
  assign hex_out     = r_hex;

endmodule

// File: tb/tb_serial_frame_scheduler.sv
// Directed bench for serial_frame_scheduler: table of single frames at two
// strobe rates plus round-robin, mid-frame reset and late input change sequences.
module tb_serial_frame_scheduler;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  req;
  logic [15:0] len_bus;
  logic [63:0] data_bus;
  logic        serOut;
  logic        serOutValid;
  logic        busy;
  logic [3:0]  ack;
  logic [6:0]  hex_out;

  int n_chk;
  int n_fail;

  typedef struct {
    int          port;
    logic [3:0]  len;
    logic [15:0] data;
    int          nsym;
    logic [31:0] exp_sym;
    logic [6:0]  exp_hex;
    logic [3:0]  exp_ack;
  } vec_t;

  vec_t vecs [5];
  vec_t chg_vec;

  serial_frame_scheduler #(.N(4), .LW(4), .DW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req        (req),
    .len_bus    (len_bus),
    .data_bus   (data_bus),
    .serOut     (serOut),
    .serOutValid(serOutValid),
    .busy       (busy),
    .ack        (ack),
    .hex_out    (hex_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    en = 1'b0;
    req = 4'b0000;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One bit period: p-1 quiet cycles (outputs must hold) then one en cycle.
  task automatic en_step(input int p);
    logic [9:0] held;
    held = {serOut, serOutValid, busy, hex_out};
    en = 1'b0;
    for (int k = 0; k < p - 1; k++) begin
      @(posedge clk);
      #1;
    end
    if (p > 1) chk("symbol hold", {18'd0, ack, held}, {18'd0, 4'b0000, serOut, serOutValid, busy, hex_out});
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input int p, input int change_at);
    logic [31:0] syms, vals, mask;
    logic [6:0]  hexv;
    int          stray;
    len_bus = 16'h0000;
    data_bus = 64'h0;
    len_bus[v.port*4 +: 4] = v.len;
    data_bus[v.port*16 +: 16] = v.data;
    req = 4'b0000;
    req[v.port] = 1'b1;
    syms = 32'd0;
    vals = 32'd0;
    stray = 0;
    hexv = 7'h00;
    for (int s = 1; s <= v.nsym; s++) begin
      en_step(p);
      syms = {syms[30:0], serOut};
      vals = {vals[30:0], serOutValid};
      if (ack !== 4'b0000 || busy !== 1'b1) stray++;
      if (s == 1) hexv = hex_out;
      if (s == change_at) begin
        req = 4'b0000;
        len_bus = 16'hFFFF;
        data_bus = {64{1'b1}};
      end
    end
    mask = (32'd1 << v.nsym) - 32'd1;
    chk("frame symbols", syms & mask, v.exp_sym);
    chk("valid window", vals & mask, ((32'd1 << v.len) - 32'd1) << 1);
    chk("busy/ack during frame", stray, 32'd0);
    chk("hex length", {25'd0, hexv}, {25'd0, v.exp_hex});
    en_step(p);
    chk("ack at stop exit", {28'd0, ack}, {28'd0, v.exp_ack});
    chk("idle after frame", {23'd0, busy, serOut, hex_out}, {23'd0, 1'b0, 1'b1, 7'h7F});
    req = 4'b0000;
    @(posedge clk);
    #1;
    chk("ack one cycle", {28'd0, ack}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] syms;
    int          stray;
    int          busy_low;
    n_chk = 0;
    n_fail = 0;
    len_bus = 16'h0000;
    data_bus = 64'h0;

    vecs[0] = '{2, 4'd3,  16'h0005, 11, 32'b0_10_0011_101_1,                   7'h30, 4'b0100};
    vecs[1] = '{1, 4'd0,  16'h0000, 8,  32'b0_01_0000_1,                       7'h40, 4'b0010};
    vecs[2] = '{3, 4'd5,  16'hABCD, 13, 32'b0_11_0101_10110_1,                 7'h12, 4'b1000};
    vecs[3] = '{0, 4'd15, 16'h8001, 23, 32'b0_00_1111_100000000000000_1,       7'h0E, 4'b0001};
    vecs[4] = '{1, 4'd1,  16'h0002, 9,  32'b0_01_0001_0_1,                     7'h79, 4'b0010};
    chg_vec = '{0, 4'd5,  16'h0015, 13, 32'b0_00_0101_10101_1,                 7'h12, 4'b0001};

    reset_dut();
    chk("reset serOut", {31'd0, serOut}, 32'd1);
    chk("reset serOutValid", {31'd0, serOutValid}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset ack", {28'd0, ack}, 32'd0);
    chk("reset hex_out", {25'd0, hex_out}, {25'd0, 7'h7F});

    // Single frames with en every cycle, then every 10th cycle.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 5; i++) begin
        run_frame(vecs[i], (r == 0) ? 1 : 10, 0);
      end
    end

    // Round-robin: ports 0,1,3 back-to-back, each holds req until its ack.
    reset_dut();
    len_bus = {4'd0, 4'd0, 4'd2, 4'd1};
    data_bus = {16'h0000, 16'h0000, 16'h0002, 16'h0001};
    req = 4'b1011;
    syms = 32'd0;
    stray = 0;
    busy_low = 0;
    for (int s = 1; s <= 28; s++) begin
      en_step(1);
      if (s <= 27) syms = {syms[30:0], serOut};
      if (s <= 27 && busy !== 1'b1) busy_low++;
      if (s == 10) chk("rr ack port0", {28'd0, ack}, 32'd1);
      else if (s == 20) chk("rr ack port1", {28'd0, ack}, 32'd2);
      else if (s == 28) chk("rr ack port3", {28'd0, ack}, 32'd8);
      else if (ack !== 4'b0000) stray++;
      if (ack !== 4'b0000) req = req & ~ack;
    end
    chk("rr symbols", syms & 32'h07FF_FFFF, 32'b0_00_0001_1_1_0_01_0010_01_1_0_11_0000_1);
    chk("rr busy continuous", busy_low, 32'd0);
    chk("rr stray ack", stray, 32'd0);
    chk("rr idle at end", {30'd0, busy, serOut}, 32'd1);

    // Mid-frame reset during DATA of a len=15 frame on port 2, with ptr at 2.
    reset_dut();
    run_frame(vecs[1], 1, 0);
    len_bus = 16'h0F00;
    data_bus = {16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
    req = 4'b0100;
    for (int s = 1; s <= 10; s++) en_step(1);
    chk("abort frame in DATA", {30'd0, busy, serOutValid}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("async reset outputs", {17'd0, serOut, serOutValid, busy, ack, hex_out},
        {17'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 7'h7F});
    req = 4'b0000;
    stray = 0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      if (ack !== 4'b0000 || serOut !== 1'b1) stray++;
    end
    rst = 1'b0;
    chk("no ack for aborted frame", stray, 32'd0);
    len_bus = 16'h0000;
    req = 4'b1111;
    syms = 32'd0;
    for (int s = 1; s <= 3; s++) begin
      en_step(1);
      syms = {syms[30:0], serOut};
    end
    chk("grant from port0 after reset", syms & 32'h7, 32'b000);
    req = 4'b0000;

    // Late input changes during LEN must not affect the latched frame.
    reset_dut();
    run_frame(chg_vec, 1, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
